// File: rtl/toggle_activity_monitor_if.sv
// Sample/report port bundle for the toggle activity monitor.
// The master drives samples and accepts records; the slave is the monitor.
interface toggle_activity_monitor_if #(
    parameter int unsigned N_SIG = 5,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned IDX_W = 3
);
    logic             start;
    logic             sample_valid;
    logic [N_SIG-1:0] sig_in;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W-1:0] rpt_idx;
    logic [CNT_W-1:0] rpt_count;
    logic             busy;
    logic             overflow;

    modport master (
        output start, sample_valid, sig_in, rpt_ready,
        input  rpt_valid, rpt_idx, rpt_count, busy, overflow
    );

    modport slave (
        input  start, sample_valid, sig_in, rpt_ready,
        output rpt_valid, rpt_idx, rpt_count, busy, overflow
    );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Counts per-bit toggles of sig_in over a window of valid samples, then streams
// one saturating count record per bit over a valid/ready port.
module toggle_activity_monitor #(
    parameter int unsigned N_SIG  = 5,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned IDX_W  = 3
) (
    input logic                      clk,
    input logic                      rst,
    toggle_activity_monitor_if.slave bus
);
    localparam int unsigned        SampleW    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0]   CntMax     = {CNT_W{1'b1}};
    localparam logic [SampleW-1:0] LastSample = SampleW'(WINDOW - 1);
    localparam logic [IDX_W-1:0]   LastIdx    = IDX_W'(N_SIG - 1);

    typedef enum logic [1:0] {StIdle, StArm, StCount, StReport} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_SIG];
    logic [N_SIG-1:0]   prev_q;
    logic [SampleW-1:0] sample_cnt_q;
    logic               overflow_q;
    logic [IDX_W-1:0]   idx_q;
    logic               rpt_fire;

    assign rpt_fire = (state_q == StReport) && bus.rpt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.start) state_d = StArm;
            StArm:    if (bus.sample_valid) state_d = StCount;
            StCount:  if (bus.sample_valid && sample_cnt_q == LastSample) state_d = StReport;
            StReport: if (rpt_fire && idx_q == LastIdx) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SIG; i++) cnt_q[i] <= '0;
            prev_q       <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            idx_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_SIG; i++) cnt_q[i] <= '0;
                        sample_cnt_q <= '0;
                        overflow_q   <= 1'b0;
                        idx_q        <= '0;
                    end
                end
                // First sample only seeds the reference; no toggle is possible yet.
                StArm: begin
                    if (bus.sample_valid) begin
                        prev_q       <= bus.sig_in;
                        sample_cnt_q <= SampleW'(1);
                    end
                end
                StCount: begin
                    if (bus.sample_valid) begin
                        for (int i = 0; i < N_SIG; i++) begin
                            if (bus.sig_in[i] ^ prev_q[i]) begin
                                if (cnt_q[i] == CntMax) overflow_q <= 1'b1;
                                else                    cnt_q[i]   <= cnt_q[i] + 1'b1;
                            end
                        end
                        prev_q       <= bus.sig_in;
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                    end
                end
                StReport: begin
                    if (rpt_fire) idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rpt_valid = 1'b0;
        bus.rpt_idx   = '0;
        bus.rpt_count = '0;
        bus.busy      = (state_q != StIdle);
        bus.overflow  = overflow_q;
        if (state_q == StReport) begin
            bus.rpt_valid = 1'b1;
            bus.rpt_idx   = idx_q;
            for (int i = 0; i < N_SIG; i++) begin
                if (idx_q == IDX_W'(i)) bus.rpt_count = cnt_q[i];
            end
        end
    end
endmodule
